// File: rtl/pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// pipeline_stall_controller
//
// Purpose: central hazard/stall controller for a 5-stage in-order pipeline.
// Resolves load-use hazards, taken branches, multi-cycle M-extension ops and
// data-memory back-pressure into per-stage stall/flush/bubble controls.
// Two-state FSM (RUN / MD_WAIT) with a 6-bit watchdog on the mul/div unit.
//
// Ports:
//   CLK             in   clock, rising edge
//   RESET           in   synchronous active-low reset
//   LU_HAZARD       in   load-use hazard between ID and EX
//   BRANCH_TAKEN_EX in   taken branch/jump resolved in EX
//   MULDIV_EX       in   EX holds an M-extension op
//   MULDIV_DONE     in   mul/div result valid (1-cycle pulse)
//   DMEM_BUSY       in   data memory not ready, freeze everything
//   STALL_IF        out  hold PC and IF/ID
//   STALL_ID_EX     out  hold ID/EX
//   STALL_EX_MEM    out  hold EX/MEM and MEM/WB
//   FLUSH_IF_ID     out  load NOP into IF/ID
//   BUBBLE_ID_EX    out  load NOP into ID/EX
//   BUBBLE_EX_MEM   out  load NOP into EX/MEM
//   MULDIV_GO       out  start pulse to the mul/div unit
//   MULDIV_TIMEOUT  out  watchdog expiry pulse
//   STATE[1:0]      out  FSM state, RUN=00 MD_WAIT=01
//   STALL_CNT[15:0] out  saturating count of STALL_IF cycles
// ---------------------------------------------------------------------------
module pipeline_stall_controller (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        LU_HAZARD,
    input  logic        BRANCH_TAKEN_EX,
    input  logic        MULDIV_EX,
    input  logic        MULDIV_DONE,
    input  logic        DMEM_BUSY,
    output logic        STALL_IF,
    output logic        STALL_ID_EX,
    output logic        STALL_EX_MEM,
    output logic        FLUSH_IF_ID,
    output logic        BUBBLE_ID_EX,
    output logic        BUBBLE_EX_MEM,
    output logic        MULDIV_GO,
    output logic        MULDIV_TIMEOUT,
    output logic [1:0]  STATE,
    output logic [15:0] STALL_CNT
);

    typedef enum logic [1:0] {
        StRun    = 2'b00,
        StMdWait = 2'b01
    } state_e;

    localparam logic [5:0]  TimerMax = 6'd63;
    localparam logic [15:0] CntMax   = 16'hFFFF;

    state_e      r_state;
    state_e      w_state_nxt;
    logic [5:0]  r_timer;
    logic [5:0]  w_timer_nxt;
    logic        r_done_pend;
    logic        w_done_pend_nxt;
    logic [15:0] r_stall_cnt;
    logic [15:0] w_stall_cnt_nxt;
    logic        w_timer_exp;
    logic        w_release;

    // A timeout only fires when nothing else has already released the op.
    assign w_timer_exp = (r_timer == TimerMax);
    assign w_release   = (r_state == StMdWait) && !DMEM_BUSY &&
                         (MULDIV_DONE || r_done_pend || w_timer_exp);

    // State register
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state     <= StRun;
            r_timer     <= 6'd0;
            r_done_pend <= 1'b0;
            r_stall_cnt <= 16'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_done_pend <= w_done_pend_nxt;
            r_stall_cnt <= w_stall_cnt_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt     = r_state;
        w_timer_nxt     = r_timer;
        w_done_pend_nxt = r_done_pend;
        if (DMEM_BUSY) begin
            // Frozen: remember a DONE pulse so it is not lost.
            if (r_state == StMdWait && MULDIV_DONE) begin
                w_done_pend_nxt = 1'b1;
            end
        end else begin
            unique case (r_state)
                StRun: begin
                    if (!BRANCH_TAKEN_EX && MULDIV_EX) begin
                        w_state_nxt = StMdWait;
                        w_timer_nxt = 6'd0;
                    end
                end
                StMdWait: begin
                    if (w_release) begin
                        w_state_nxt     = StRun;
                        w_done_pend_nxt = 1'b0;
                    end else begin
                        w_timer_nxt = r_timer + 6'd1;
                    end
                end
                default: begin
                    w_state_nxt = StRun;
                end
            endcase
        end
    end

    // Output logic
    always_comb begin
        STALL_IF       = 1'b0;
        STALL_ID_EX    = 1'b0;
        STALL_EX_MEM   = 1'b0;
        FLUSH_IF_ID    = 1'b0;
        BUBBLE_ID_EX   = 1'b0;
        BUBBLE_EX_MEM  = 1'b0;
        MULDIV_GO      = 1'b0;
        MULDIV_TIMEOUT = 1'b0;
        if (!RESET) begin
            // all controls stay 0 while reset is held
        end else if (DMEM_BUSY) begin
            STALL_IF     = 1'b1;
            STALL_ID_EX  = 1'b1;
            STALL_EX_MEM = 1'b1;
        end else begin
            unique case (r_state)
                StRun: begin
                    if (BRANCH_TAKEN_EX) begin
                        FLUSH_IF_ID  = 1'b1;
                        BUBBLE_ID_EX = 1'b1;
                    end else if (MULDIV_EX) begin
                        MULDIV_GO     = 1'b1;
                        STALL_IF      = 1'b1;
                        STALL_ID_EX   = 1'b1;
                        BUBBLE_EX_MEM = 1'b1;
                    end else if (LU_HAZARD) begin
                        STALL_IF     = 1'b1;
                        BUBBLE_ID_EX = 1'b1;
                    end
                end
                StMdWait: begin
                    if (w_release) begin
                        // Release cycle: EX/MEM captures the result.
                        MULDIV_TIMEOUT = w_timer_exp && !MULDIV_DONE && !r_done_pend;
                    end else begin
                        STALL_IF      = 1'b1;
                        STALL_ID_EX   = 1'b1;
                        BUBBLE_EX_MEM = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_stall_cnt_nxt = r_stall_cnt;
        if (STALL_IF && r_stall_cnt != CntMax) begin
            w_stall_cnt_nxt = r_stall_cnt + 16'd1;
        end
    end

    assign STATE     = r_state;
    assign STALL_CNT = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// tb_pipeline_stall_controller
//
// Directed-vector bench. Inputs change 1 ns after the rising edge, the
// combinational controls are sampled mid-cycle, registered outputs 1 ns
// after the edge.
// ---------------------------------------------------------------------------
module tb_pipeline_stall_controller;

    logic        clk;
    logic        rst_n;
    logic        lu;
    logic        br;
    logic        mx;
    logic        done;
    logic        busy;
    logic        stall_if;
    logic        stall_id_ex;
    logic        stall_ex_mem;
    logic        flush_if_id;
    logic        bubble_id_ex;
    logic        bubble_ex_mem;
    logic        md_go;
    logic        md_tmo;
    logic [1:0]  state;
    logic [15:0] stall_cnt;

    int checks;
    int errors;

    // Control vector order:
    // {STALL_IF, STALL_ID_EX, STALL_EX_MEM, FLUSH_IF_ID,
    //  BUBBLE_ID_EX, BUBBLE_EX_MEM, MULDIV_GO, MULDIV_TIMEOUT}
    localparam logic [7:0] CNone   = 8'b0000_0000;
    localparam logic [7:0] CFreeze = 8'b1110_0000;
    localparam logic [7:0] CBr     = 8'b0001_1000;
    localparam logic [7:0] CGo     = 8'b1100_0110;
    localparam logic [7:0] CLu     = 8'b1000_1000;
    localparam logic [7:0] CWait   = 8'b1100_0100;
    localparam logic [7:0] CTmo    = 8'b0000_0001;

    // Input vector order: {LU_HAZARD, BRANCH_TAKEN_EX, MULDIV_EX, MULDIV_DONE, DMEM_BUSY}
    localparam logic [4:0] IIdle = 5'b00000;
    localparam logic [4:0] ILu   = 5'b10000;
    localparam logic [4:0] IBr   = 5'b01000;
    localparam logic [4:0] IMx   = 5'b00100;
    localparam logic [4:0] IDone = 5'b00010;
    localparam logic [4:0] IBusy = 5'b00001;

    pipeline_stall_controller u_dut (
        .CLK             (clk),
        .RESET           (rst_n),
        .LU_HAZARD       (lu),
        .BRANCH_TAKEN_EX (br),
        .MULDIV_EX       (mx),
        .MULDIV_DONE     (done),
        .DMEM_BUSY       (busy),
        .STALL_IF        (stall_if),
        .STALL_ID_EX     (stall_id_ex),
        .STALL_EX_MEM    (stall_ex_mem),
        .FLUSH_IF_ID     (flush_if_id),
        .BUBBLE_ID_EX    (bubble_id_ex),
        .BUBBLE_EX_MEM   (bubble_ex_mem),
        .MULDIV_GO       (md_go),
        .MULDIV_TIMEOUT  (md_tmo),
        .STATE           (state),
        .STALL_CNT       (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ctl();
        return {stall_if, stall_id_ex, stall_ex_mem, flush_if_id,
                bubble_id_ex, bubble_ex_mem, md_go, md_tmo};
    endfunction

    // One clock cycle: apply inputs, check controls mid-cycle, advance past the edge.
    task automatic cyc(input string tag, input logic [4:0] iv, input logic [7:0] exp_ctl);
        {lu, br, mx, done, busy} = iv;
        #4;
        check(tag, {24'd0, ctl()}, {24'd0, exp_ctl});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc("rst_ctl", IIdle, CNone);
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        {lu, br, mx, done, busy} = IIdle;
        @(posedge clk);
        #1;

        // Reset overrides active inputs; controls stay 0.
        cyc("rst_mx_lu", 5'b10100, CNone);
        cyc("rst_busy", IBusy, CNone);
        rst_n = 1'b1;
        check("rst_state", {30'd0, state}, 32'd0);
        check("rst_cnt", {16'd0, stall_cnt}, 32'd0);
        cyc("idle", IIdle, CNone);

        // Load-use hazard, one cycle.
        cyc("lu", ILu, CLu);
        check("lu_state", {30'd0, state}, 32'd0);
        check("lu_cnt", {16'd0, stall_cnt}, 32'd1);
        cyc("lu_after", IIdle, CNone);

        // Mul/div with DONE four cycles after GO.
        do_reset();
        cyc("md_go", IMx, CGo);
        check("md_state1", {30'd0, state}, 32'd1);
        cyc("md_w1", IIdle, CWait);
        cyc("md_w2_br_lu", 5'b11000, CWait);
        cyc("md_w3", IMx, CWait);
        cyc("md_rel", IDone, CNone);
        check("md_state0", {30'd0, state}, 32'd0);
        check("md_cnt", {16'd0, stall_cnt}, 32'd4);
        cyc("run_done_ign", IDone, CNone);
        check("run_done_state", {30'd0, state}, 32'd0);
        cyc("run_after_done", IIdle, CNone);

        // DONE arrives while memory is busy; release on first non-busy cycle.
        do_reset();
        cyc("fz_go", IMx, CGo);
        cyc("fz_w1", IIdle, CWait);
        cyc("fz_busy_done", IDone | IBusy, CFreeze);
        check("fz_state", {30'd0, state}, 32'd1);
        cyc("fz_busy2", IBusy, CFreeze);
        cyc("fz_busy3", IBusy, CFreeze);
        cyc("fz_rel", IIdle, CNone);
        check("fz_state0", {30'd0, state}, 32'd0);
        check("fz_cnt", {16'd0, stall_cnt}, 32'd5);
        cyc("fz_after", IIdle, CNone);

        // Watchdog: 63 non-busy waits, busy cycles hold the timer, 64th waits times out.
        do_reset();
        cyc("to_go", IMx, CGo);
        for (int i = 0; i < 10; i++) cyc("to_wait_a", IIdle, CWait);
        for (int i = 0; i < 5; i++) cyc("to_busy", IBusy, CFreeze);
        for (int i = 0; i < 53; i++) cyc("to_wait_b", IIdle, CWait);
        check("to_state_pre", {30'd0, state}, 32'd1);
        cyc("to_pulse", IIdle, CTmo);
        check("to_state0", {30'd0, state}, 32'd0);
        check("to_cnt", {16'd0, stall_cnt}, 32'd69);
        cyc("to_after", IIdle, CNone);

        // Branch beats muldiv and load-use.
        do_reset();
        cyc("br_all", ILu | IBr | IMx, CBr);
        check("br_state", {30'd0, state}, 32'd0);
        cyc("br_only", IBr, CBr);
        cyc("lu_mx_prio", ILu | IMx, CGo);
        cyc("prio_rel", IDone, CNone);

        // Saturation, then reset while in MD_WAIT.
        do_reset();
        cyc("sat_go", IMx, CGo);
        {lu, br, mx, done, busy} = IBusy;
        repeat (69999) @(posedge clk);
        #1;
        check("sat_state", {30'd0, state}, 32'd1);
        check("sat_cnt", {16'd0, stall_cnt}, 32'hFFFF);
        cyc("sat_busy_ctl", IBusy, CFreeze);
        check("sat_hold", {16'd0, stall_cnt}, 32'hFFFF);
        rst_n = 1'b0;
        cyc("sat_rst", IIdle, CNone);
        rst_n = 1'b1;
        check("sat_rst_state", {30'd0, state}, 32'd0);
        check("sat_rst_cnt", {16'd0, stall_cnt}, 32'd0);
        cyc("post_rst1", IIdle, CNone);
        cyc("post_rst_done", IDone, CNone);
        check("post_rst_state", {30'd0, state}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_controller.md
PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

Interface
REQ-001 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port RESET  input  1  reset, synchronous, active-low (0 = reset).
REQ-003 SHALL have port LU_HAZARD  input  1  load-use hazard between the ID and EX stages.
REQ-004 SHALL have port BRANCH_TAKEN_EX  input  1  taken branch/jump resolved in EX.
REQ-005 SHALL have port MULDIV_EX  input  1  instruction in EX is an M-extension op.
REQ-006 SHALL have port MULDIV_DONE  input  1  mul/div unit result valid, 1-cycle pulse.
REQ-007 SHALL have port DMEM_BUSY  input  1  data memory not ready; whole pipeline must freeze.
REQ-008 SHALL have port STALL_IF  output  1  hold PC and the IF/ID register.
REQ-009 SHALL have port STALL_ID_EX  output  1  hold the ID/EX register.
REQ-010 SHALL have port STALL_EX_MEM  output  1  hold the EX/MEM and MEM/WB registers.
REQ-011 SHALL have port FLUSH_IF_ID  output  1  load NOP into IF/ID.
REQ-012 SHALL have port BUBBLE_ID_EX  output  1  load NOP into ID/EX.
REQ-013 SHALL have port BUBBLE_EX_MEM  output  1  load NOP into EX/MEM.
REQ-014 SHALL have port MULDIV_GO  output  1  start pulse to the mul/div unit.
REQ-015 SHALL have port MULDIV_TIMEOUT  output  1  watchdog expiry pulse.
REQ-016 SHALL have port STATE  output  2  current FSM state: RUN=00, MD_WAIT=01.
REQ-017 SHALL have port STALL_CNT  output  16  count of cycles with STALL_IF=1.

Function
REQ-018 SHALL register STATE, a 6-bit watchdog timer, a done_pend flag and STALL_CNT; all other outputs SHALL be combinational functions of state and current inputs.
REQ-019 DMEM_BUSY=1, any state: SHALL assert STALL_IF, STALL_ID_EX and STALL_EX_MEM; all FLUSH/BUBBLE/GO outputs 0; STATE held; timer held.
REQ-020 RUN, !DMEM_BUSY, BRANCH_TAKEN_EX=1: SHALL assert FLUSH_IF_ID and BUBBLE_ID_EX; no stalls; LU_HAZARD and MULDIV_EX ignored.
REQ-021 RUN, !DMEM_BUSY, MULDIV_EX=1, no branch: SHALL assert MULDIV_GO, STALL_IF, STALL_ID_EX and BUBBLE_EX_MEM; next state MD_WAIT; timer cleared to 0.
REQ-022 RUN, !DMEM_BUSY, LU_HAZARD=1, no branch, no muldiv: SHALL assert STALL_IF and BUBBLE_ID_EX for that cycle only; state stays RUN.
REQ-023 RUN with no condition active: all control outputs SHALL be 0.
REQ-024 MD_WAIT, !DMEM_BUSY, no release: SHALL assert STALL_IF, STALL_ID_EX and BUBBLE_EX_MEM; timer increments; LU_HAZARD and BRANCH_TAKEN_EX ignored; MULDIV_GO=0.
REQ-025 Release condition SHALL be (MULDIV_DONE or done_pend) with !DMEM_BUSY; in the release cycle all stalls and bubbles SHALL be 0 (EX/MEM captures result), done_pend clears, next state RUN.
REQ-026 MULDIV_DONE while DMEM_BUSY=1 in MD_WAIT SHALL set done_pend; release SHALL occur in the first cycle DMEM_BUSY=0.
REQ-027 Timer reaching 63 in MD_WAIT without release: SHALL pulse MULDIV_TIMEOUT for 1 cycle and treat that cycle as a release cycle (REQ-025).
REQ-028 MULDIV_DONE in RUN SHALL be ignored; done_pend is never set in RUN.
REQ-029 STALL_CNT SHALL increment by 1 on each cycle with STALL_IF=1 and saturate at 16'hFFFF.
REQ-030 MULDIV_GO SHALL assert only on the RUN->MD_WAIT transition cycle, never twice for one instruction.

Reset
REQ-031 RESET=0 at a rising edge SHALL set STATE=RUN, timer=0, done_pend=0, STALL_CNT=0, overriding all other inputs.
REQ-032 While RESET=0, all combinational control outputs SHALL be 0.
REQ-033 Reset in MD_WAIT SHALL abandon the op: no MULDIV_TIMEOUT, and no release-cycle outputs afterwards.

Verification
REQ-034 LU_HAZARD=1 for 1 cycle in RUN -> STALL_IF=1 and BUBBLE_ID_EX=1 that cycle, STATE=00, STALL_CNT=1.
REQ-035 MULDIV_EX=1, then MULDIV_DONE 4 cycles later -> GO pulse once, 4 stall cycles, release cycle with all outputs 0, STATE back to 00, STALL_CNT=4.
REQ-036 MD_WAIT, DMEM_BUSY=1 over the DONE pulse for 3 cycles -> full freeze; release in the first cycle DMEM_BUSY=0.
REQ-037 MULDIV_EX with no DONE -> MULDIV_TIMEOUT pulses on the 64th MD_WAIT cycle, STATE=00 next.
REQ-038 BRANCH_TAKEN_EX=1 with LU_HAZARD=1 and MULDIV_EX=1 -> only FLUSH_IF_ID=1 and BUBBLE_ID_EX=1, MULDIV_GO=0.
REQ-039 RESET=0 mid-MD_WAIT with 70000 prior stall cycles -> STATE=00, STALL_CNT=0; STALL_CNT read FFFF before reset.
